// File: rtl/csr_trap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : csr_trap_ctrl_pkg                                           |
// | Purpose : Shared state encoding, CSR addresses, exception codes and   |
// |           mstatus bit positions for the machine-mode trap sequencer.  |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package csr_trap_ctrl_pkg;

  // Sequencer states: T_* walk the trap entry, M_* walk the mret exit.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_TVAL   = 3'd2,
    T_CAUSE  = 3'd3,
    T_STATUS = 3'd4,
    T_REDIR  = 3'd5,
    M_STATUS = 3'd6,
    M_REDIR  = 3'd7
  } state_t;

  // CSR addresses written by the sequencer.
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  // Exception codes carried on exception_i / exception_o.
  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_ECALL   = 2'b10;
  localparam logic [1:0] EXC_EBREAK  = 2'b11;

  // mstatus field positions.
  localparam int MIE_BIT    = 3;
  localparam int MPIE_BIT   = 7;
  localparam int MPP_HI_BIT = 12;
  localparam int MPP_LO_BIT = 11;

endpackage : csr_trap_ctrl_pkg
`default_nettype wire

// File: rtl/csr_trap_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : csr_trap_ctrl_if                                            |
// | Purpose : Pipeline / CSR-bus / fetch-redirect signal bundle for the   |
// |           trap sequencer. master = surroundings, slave = sequencer.   |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface csr_trap_ctrl_if;

  // Trap / mret sources and current CSR values
  logic [1:0]  exception_i;
  logic        mret_i;
  logic [31:0] pc_i;
  logic [31:0] tval_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;

  // Pipeline CSR request
  logic        csr_req_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_set_i;
  logic [31:0] csr_clear_i;
  logic        csr_gnt_o;

  // Shared set/clear CSR bus
  logic        csr_en_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_set_o;
  logic [31:0] csr_clear_o;
  logic        csr_ack_i;

  // Trap side-band and fetch control
  logic [1:0]  exception_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        bus_err_o;

  modport master (
    output exception_i, mret_i, pc_i, tval_i, mtvec_i, mepc_i, mstatus_i,
    output csr_req_i, csr_addr_i, csr_set_i, csr_clear_i, csr_ack_i,
    input  csr_gnt_o, csr_en_o, csr_addr_o, csr_set_o, csr_clear_o,
    input  exception_o, stall_o, redirect_o, redirect_pc_o, bus_err_o
  );

  modport slave (
    input  exception_i, mret_i, pc_i, tval_i, mtvec_i, mepc_i, mstatus_i,
    input  csr_req_i, csr_addr_i, csr_set_i, csr_clear_i, csr_ack_i,
    output csr_gnt_o, csr_en_o, csr_addr_o, csr_set_o, csr_clear_o,
    output exception_o, stall_o, redirect_o, redirect_pc_o, bus_err_o
  );

endinterface : csr_trap_ctrl_if
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : csr_trap_ctrl                                               |
// | Purpose : Machine-mode trap sequencer. Owns the set/clear CSR bus,    |
// |           writes mepc/mtval/mcause/mstatus on a trap, restores        |
// |           mstatus on mret and redirects fetch.                        |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  csr_trap_ctrl_if.slave  bus
);

  state_t      state;
  logic [29:0] trap_pc;    // word-aligned PC, low two bits are always zero
  logic [31:0] trap_tval;
  logic [1:0]  trap_code;

  logic        trap_req;
  logic        event_req;
  logic [31:0] epc_val;
  logic        unused_bits;

  assign trap_req  = (bus.exception_i != EXC_NONE);
  assign event_req = trap_req || bus.mret_i;
  assign epc_val   = {trap_pc, 2'b00};

  // Only some bits of these inputs matter; the rest are intentionally dropped.
  assign unused_bits = ^{bus.pc_i[1:0], bus.mtvec_i[1:0],
                         bus.mstatus_i[31:8], bus.mstatus_i[6:4], bus.mstatus_i[2:0]};

  // Sequencer state and trap context capture; traps/mret accepted only in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      trap_pc   <= '0;
      trap_tval <= '0;
      trap_code <= EXC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            state     <= T_EPC;
            trap_pc   <= bus.pc_i[31:2];
            trap_tval <= bus.tval_i;
            trap_code <= bus.exception_i;
          end else if (bus.mret_i) begin
            state <= M_STATUS;
          end
        end
        T_EPC:    state <= T_TVAL;
        T_TVAL:   state <= T_CAUSE;
        T_CAUSE:  state <= T_STATUS;
        T_STATUS: state <= T_REDIR;
        T_REDIR:  state <= IDLE;
        M_STATUS: state <= M_REDIR;
        M_REDIR:  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // CSR bus mux: pipeline passthrough in quiet IDLE, sequencer writes otherwise.
  always_comb begin
    bus.csr_gnt_o     = 1'b0;
    bus.csr_en_o      = 1'b0;
    bus.csr_addr_o    = '0;
    bus.csr_set_o     = '0;
    bus.csr_clear_o   = '0;
    bus.exception_o   = EXC_NONE;
    bus.stall_o       = 1'b1;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    bus.bus_err_o     = 1'b0;
    case (state)
      IDLE: begin
        bus.stall_o = event_req;
        if (!event_req) begin
          bus.csr_gnt_o   = bus.csr_req_i;
          bus.csr_en_o    = bus.csr_req_i;
          bus.csr_addr_o  = bus.csr_addr_i;
          bus.csr_set_o   = bus.csr_set_i;
          bus.csr_clear_o = bus.csr_clear_i;
        end
      end
      T_EPC: begin
        bus.csr_en_o    = 1'b1;
        bus.csr_addr_o  = CSR_MEPC;
        bus.csr_set_o   = epc_val;
        bus.csr_clear_o = ~epc_val;
        bus.bus_err_o   = ~bus.csr_ack_i;
      end
      T_TVAL: begin
        bus.csr_en_o    = 1'b1;
        bus.csr_addr_o  = CSR_MTVAL;
        bus.csr_set_o   = trap_tval;
        bus.csr_clear_o = ~trap_tval;
        bus.bus_err_o   = ~bus.csr_ack_i;
      end
      // mcause derives the cause from the code itself; the bus stays idle.
      T_CAUSE: begin
        bus.exception_o = trap_code;
      end
      // Enter M-mode: MPP=11, MPIE<=MIE, MIE<=0.
      T_STATUS: begin
        bus.csr_en_o                     = 1'b1;
        bus.csr_addr_o                   = CSR_MSTATUS;
        bus.csr_set_o[MPP_HI_BIT]        = 1'b1;
        bus.csr_set_o[MPP_LO_BIT]        = 1'b1;
        bus.csr_set_o[MPIE_BIT]          = bus.mstatus_i[MIE_BIT];
        bus.csr_clear_o[MIE_BIT]         = 1'b1;
        bus.csr_clear_o[MPIE_BIT]        = ~bus.mstatus_i[MIE_BIT];
        bus.bus_err_o                    = ~bus.csr_ack_i;
      end
      T_REDIR: begin
        bus.redirect_o    = 1'b1;
        bus.redirect_pc_o = {bus.mtvec_i[31:2], 2'b00};
      end
      // Leave M-mode: MIE<=MPIE, MPIE<=1.
      M_STATUS: begin
        bus.csr_en_o              = 1'b1;
        bus.csr_addr_o            = CSR_MSTATUS;
        bus.csr_set_o[MIE_BIT]    = bus.mstatus_i[MPIE_BIT];
        bus.csr_set_o[MPIE_BIT]   = 1'b1;
        bus.csr_clear_o[MIE_BIT]  = ~bus.mstatus_i[MPIE_BIT];
        bus.bus_err_o             = ~bus.csr_ack_i;
      end
      M_REDIR: begin
        bus.redirect_o    = 1'b1;
        bus.redirect_pc_o = bus.mepc_i;
      end
      default: begin
        bus.stall_o = 1'b1;
      end
    endcase
  end

endmodule : csr_trap_ctrl
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_csr_trap_ctrl                                            |
// | Purpose : Scoreboard bench for csr_trap_ctrl. Each driven cycle       |
// |           queues the outputs expected in that cycle; a negedge        |
// |           monitor pops and compares them.                             |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_csr_trap_ctrl;

  typedef struct {
    logic        stall;
    logic        en;
    logic [11:0] addr;
    logic [31:0] set;
    logic [31:0] clr;
    logic        berr;
    logic        gnt;
    logic [1:0]  exc;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;

  csr_trap_ctrl_if b ();

  csr_trap_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (b)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic stall, input logic en, input logic [11:0] addr,
                              input logic [31:0] set, input logic [31:0] clr, input logic berr,
                              input logic gnt, input logic [1:0] exc, input logic redir,
                              input logic [31:0] rpc);
    exp_t e;
    e.stall = stall; e.en = en; e.addr = addr; e.set = set; e.clr = clr;
    e.berr = berr; e.gnt = gnt; e.exc = exc; e.redir = redir; e.rpc = rpc;
    return e;
  endfunction

  function automatic exp_t quiet();
    return mk(1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
  endfunction

  // Queue expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("stall",    {31'b0, b.stall_o},    {31'b0, cur.stall});
      chk("csr_en",   {31'b0, b.csr_en_o},   {31'b0, cur.en});
      chk("csr_addr", {20'b0, b.csr_addr_o}, {20'b0, cur.addr});
      chk("csr_set",  b.csr_set_o,           cur.set);
      chk("csr_clr",  b.csr_clear_o,         cur.clr);
      chk("bus_err",  {31'b0, b.bus_err_o},  {31'b0, cur.berr});
      chk("csr_gnt",  {31'b0, b.csr_gnt_o},  {31'b0, cur.gnt});
      chk("exc_out",  {30'b0, b.exception_o},{30'b0, cur.exc});
      chk("redirect", {31'b0, b.redirect_o}, {31'b0, cur.redir});
      chk("redir_pc", b.redirect_pc_o,       cur.rpc);
    end
  end

  task automatic idle_inputs();
    b.exception_i = 2'b00; b.mret_i = 1'b0;
    b.csr_req_i = 1'b0; b.csr_addr_i = 12'h0; b.csr_set_i = 32'h0; b.csr_clear_i = 32'h0;
    b.csr_ack_i = 1'b1;
  endtask

  // Full trap sequence, detect cycle N through redirect at N+5.
  // with_extra also raises mret_i and a held pipeline request in the detect cycle.
  task automatic run_trap(input logic [1:0] code, input logic [31:0] pc, input logic [31:0] tval,
                          input logic [31:0] ms, input logic [31:0] tvec, input logic ack,
                          input logic with_extra);
    logic [31:0] epc;
    logic [31:0] st_set;
    logic [31:0] st_clr;
    epc    = {pc[31:2], 2'b00};
    st_set = 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
    st_clr = 32'h0000_0008 | (ms[3] ? 32'h0 : 32'h80);
    b.exception_i = code; b.pc_i = pc; b.tval_i = tval;
    b.mstatus_i = ms; b.mtvec_i = tvec; b.csr_ack_i = ack;
    if (with_extra) begin
      b.mret_i = 1'b1; b.csr_req_i = 1'b1; b.csr_addr_i = 12'h305;
      b.csr_set_i = 32'hFF; b.csr_clear_i = 32'h0;
    end
    cyc(mk(1, 0, 12'h0, 0, 0, 0, 0, 2'b00, 0, 0));
    // Scramble live inputs to show the sequencer uses its captured copies.
    b.exception_i = 2'b00; b.mret_i = 1'b0; b.pc_i = 32'hFFFF_FFFF; b.tval_i = 32'h1234_5678;
    cyc(mk(1, 1, 12'h341, epc, ~epc, ~ack, 0, 2'b00, 0, 0));
    cyc(mk(1, 1, 12'h343, tval, ~tval, ~ack, 0, 2'b00, 0, 0));
    cyc(mk(1, 0, 12'h000, 0, 0, 0, 0, code, 0, 0));
    cyc(mk(1, 1, 12'h300, st_set, st_clr, ~ack, 0, 2'b00, 0, 0));
    cyc(mk(1, 0, 12'h000, 0, 0, 0, 0, 2'b00, 1, {tvec[31:2], 2'b00}));
    b.csr_ack_i = 1'b1;
  endtask

  initial begin
    idle_inputs();
    b.pc_i = 32'h0; b.tval_i = 32'h0; b.mtvec_i = 32'h0; b.mepc_i = 32'h0; b.mstatus_i = 32'h0;

    // Reset state
    @(posedge clk_i); #1;
    cyc(quiet());
    rst_i = 1'b0;
    cyc(quiet());

    // Ecall with MIE=1
    run_trap(2'b10, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0008, 32'h0000_0203, 1'b1, 1'b0);
    cyc(quiet());

    // Mret with MPIE=1
    b.mstatus_i = 32'h0000_0080; b.mepc_i = 32'h0000_0104; b.mret_i = 1'b1;
    cyc(mk(1, 0, 12'h0, 0, 0, 0, 0, 2'b00, 0, 0));
    b.mret_i = 1'b0;
    cyc(mk(1, 1, 12'h300, 32'h88, 32'h0, 0, 0, 2'b00, 0, 0));
    cyc(mk(1, 0, 12'h0, 0, 0, 0, 0, 2'b00, 1, 32'h104));
    cyc(quiet());

    // Mret with MPIE=0 restores MIE=0
    b.mstatus_i = 32'h0000_0008; b.mepc_i = 32'h0000_0ABC; b.mret_i = 1'b1;
    cyc(mk(1, 0, 12'h0, 0, 0, 0, 0, 2'b00, 0, 0));
    b.mret_i = 1'b0;
    cyc(mk(1, 1, 12'h300, 32'h80, 32'h8, 0, 0, 2'b00, 0, 0));
    cyc(mk(1, 0, 12'h0, 0, 0, 0, 0, 2'b00, 1, 32'hABC));

    // Pipeline passthrough
    b.csr_req_i = 1'b1; b.csr_addr_i = 12'h305; b.csr_set_i = 32'hFF; b.csr_clear_i = 32'h0;
    cyc(mk(0, 1, 12'h305, 32'hFF, 32'h0, 0, 1, 2'b00, 0, 0));
    b.csr_addr_i = 12'h7C0; b.csr_set_i = 32'h0; b.csr_clear_i = 32'hF0F0_0001; b.csr_ack_i = 1'b0;
    cyc(mk(0, 1, 12'h7C0, 32'h0, 32'hF0F0_0001, 0, 1, 2'b00, 0, 0));
    idle_inputs();

    // Exception + mret + pipeline request together: trap wins, request granted at N+6
    run_trap(2'b01, 32'h0000_0A02, 32'h0000_0055, 32'h0, 32'h0000_0203, 1'b1, 1'b1);
    cyc(mk(0, 1, 12'h305, 32'hFF, 32'h0, 0, 1, 2'b00, 0, 0));
    idle_inputs();
    cyc(quiet());

    // No ack during trap, immediately followed by a back-to-back ecall
    run_trap(2'b11, 32'h0000_0200, 32'h0, 32'h0000_0008, 32'h8000_0000, 1'b0, 1'b0);
    run_trap(2'b10, 32'h0000_0300, 32'h0000_00AA, 32'h0, 32'h0000_0400, 1'b1, 1'b0);
    cyc(quiet());

    // Reset asserted while in T_TVAL
    b.exception_i = 2'b10; b.pc_i = 32'h0000_0500; b.tval_i = 32'h0000_0011;
    b.mstatus_i = 32'h8; b.mtvec_i = 32'h0000_0600;
    cyc(mk(1, 0, 12'h0, 0, 0, 0, 0, 2'b00, 0, 0));
    b.exception_i = 2'b00;
    cyc(mk(1, 1, 12'h341, 32'h500, ~32'h500, 0, 0, 2'b00, 0, 0));
    rst_i = 1'b1;
    cyc(mk(1, 1, 12'h343, 32'h11, ~32'h11, 0, 0, 2'b00, 0, 0));
    rst_i = 1'b0;
    repeat (6) cyc(quiet());

    chk("queue_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_csr_trap_ctrl
`default_nettype wire
